// File: rtl/pid_mc_pkg.sv
// rtl/pid_mc_pkg.sv - shared FSM state type, accumulator width and saturation helper for pid_speed_ctrl_mc
package pid_mc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LATCH,
        CALC,
        COMMIT
    } pid_state_e;

    // Wide enough for any PID product and sum at the supported parameter ranges.
    localparam int ACC_W = 48;

    function automatic logic signed [ACC_W-1:0] sat_signed(input logic signed [ACC_W-1:0] x,
                                                           input int lim);
        logic signed [ACC_W-1:0] l;
        l = ACC_W'(lim);
        if (x > l) begin
            return l;
        end else if (x < -l) begin
            return -l;
        end
        return x;
    endfunction

endpackage

// File: rtl/enc_edge_counter.sv
// rtl/enc_edge_counter.sv - encoder input synchroniser, rising-edge detector and saturating window counter
module enc_edge_counter #(
    parameter int CNT_W = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enc,
    input  logic             latch,
    output logic [CNT_W-1:0] meas
);
    logic [2:0]       sync_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] meas_q;
    logic             edge_w;

    assign edge_w = sync_q[1] & ~sync_q[2];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
            cnt_q  <= '0;
            meas_q <= '0;
        end else begin
            sync_q <= {sync_q[1:0], enc};
            // An edge arriving in the latch cycle belongs to the new window.
            if (latch) begin
                meas_q <= cnt_q;
                cnt_q  <= CNT_W'(edge_w);
            end else if (edge_w && (cnt_q != '1)) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign meas = meas_q;

endmodule

// File: rtl/pid_speed_ctrl_mc.sv
// rtl/pid_speed_ctrl_mc.sv - multi-channel PID wheel-speed controller, one shared time-multiplexed datapath
// Define PID_DTERM_EN to include the derivative term; without it the loop is PI only and kd is ignored.
module pid_speed_ctrl_mc
    import pid_mc_pkg::*;
#(
    parameter int CH         = 4,
    parameter int CNT_W      = 10,
    parameter int PWM_W      = 8,
    parameter int SAMPLE_DIV = 50000,
    parameter int GAIN_W     = 8,
    parameter int GAIN_SHIFT = 4,
    parameter int INT_LIM    = 2047
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [CH-1:0]           enc,
    input  logic [CH*(CNT_W+1)-1:0] setpoint,
    input  logic [GAIN_W-1:0]       kp,
    input  logic [GAIN_W-1:0]       ki,
    input  logic [GAIN_W-1:0]       kd,
    output logic [CH-1:0]           pwm_out,
    output logic [CH-1:0]           dir,
    output logic                    update_done
);
    localparam int SP_W    = CNT_W + 1;
    localparam int ERR_W   = CNT_W + 2;
    localparam int INT_W   = $clog2(INT_LIM + 1) + 1;
    localparam int DIV_W   = $clog2(SAMPLE_DIV);
    localparam int CH_W    = (CH > 1) ? $clog2(CH) : 1;
    localparam int PWM_MAX = (1 << PWM_W) - 1;

    pid_state_e              state_q, state_d;
    logic [DIV_W-1:0]        presc_q;
    logic                    tick;
    logic                    latch_q;
    logic [CH_W-1:0]         ch_q;
    logic                    last_ch;
    logic [GAIN_W-1:0]       kp_q;
    logic [GAIN_W-1:0]       ki_q;
    logic signed [SP_W-1:0]  sp_q      [CH];
    logic signed [INT_W-1:0] integ_q   [CH];
    logic [PWM_W-1:0]        duty_q    [CH];
    logic [PWM_W-1:0]        duty_sh_q [CH];
    logic [CH-1:0]           dir_q;
    logic [CH-1:0]           dir_sh_q;
    logic                    update_done_q;
    logic [PWM_W-1:0]        pwm_cnt_q;
    logic [CNT_W-1:0]        meas_w    [CH];

    logic signed [ACC_W-1:0] err_a, integ_a, d_a, sum_a, u_a;
    logic [PWM_W-1:0]        duty_new;
    logic                    dir_new;

`ifdef PID_DTERM_EN
    logic [GAIN_W-1:0]       kd_q;
    logic signed [ERR_W-1:0] err_prev_q [CH];
`else
    logic unused_kd;
    assign unused_kd = ^kd;
`endif

    for (genvar g = 0; g < CH; g++) begin : g_enc
        enc_edge_counter #(
            .CNT_W(CNT_W)
        ) u_enc (
            .clk  (clk),
            .reset(reset),
            .enc  (enc[g]),
            .latch(latch_q),
            .meas (meas_w[g])
        );
    end

    assign tick    = (presc_q == DIV_W'(SAMPLE_DIV - 1));
    assign last_ch = (ch_q == CH_W'(CH - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc_q   <= '0;
            latch_q   <= 1'b0;
            pwm_cnt_q <= '0;
        end else begin
            presc_q   <= tick ? '0 : presc_q + 1'b1;
            latch_q   <= tick;
            pwm_cnt_q <= pwm_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (tick) state_d = LATCH;
            LATCH:   state_d = CALC;
            CALC:    if (last_ch) state_d = COMMIT;
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (!enable) begin
            state_d = IDLE;
        end
    end

    // Datapath for the channel selected by ch_q; integ_a is the freshly clamped integrator.
    always_comb begin
        err_a   = ACC_W'(sp_q[ch_q]) - ACC_W'(meas_w[ch_q]);
        integ_a = sat_signed(ACC_W'(integ_q[ch_q]) + err_a, INT_LIM);
`ifdef PID_DTERM_EN
        d_a     = ACC_W'(kd_q) * (err_a - ACC_W'(err_prev_q[ch_q]));
`else
        d_a     = '0;
`endif
        sum_a    = ACC_W'(kp_q) * err_a + ACC_W'(ki_q) * integ_a + d_a;
        u_a      = sat_signed(sum_a >>> GAIN_SHIFT, PWM_MAX);
        dir_new  = u_a[ACC_W-1];
        duty_new = dir_new ? PWM_W'(-u_a) : PWM_W'(u_a);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ch_q          <= '0;
            kp_q          <= '0;
            ki_q          <= '0;
            dir_q         <= '0;
            dir_sh_q      <= '0;
            update_done_q <= 1'b0;
            for (int i = 0; i < CH; i++) begin
                sp_q[i]      <= '0;
                integ_q[i]   <= '0;
                duty_q[i]    <= '0;
                duty_sh_q[i] <= '0;
            end
        end else begin
            update_done_q <= 1'b0;
            if (!enable) begin
                ch_q     <= '0;
                dir_q    <= '0;
                dir_sh_q <= '0;
                for (int i = 0; i < CH; i++) begin
                    integ_q[i]   <= '0;
                    duty_q[i]    <= '0;
                    duty_sh_q[i] <= '0;
                end
            end else begin
                case (state_q)
                    LATCH: begin
                        ch_q <= '0;
                        kp_q <= kp;
                        ki_q <= ki;
                        for (int i = 0; i < CH; i++) begin
                            sp_q[i] <= setpoint[i*SP_W +: SP_W];
                        end
                    end
                    CALC: begin
                        integ_q[ch_q]   <= INT_W'(integ_a);
                        duty_sh_q[ch_q] <= duty_new;
                        dir_sh_q[ch_q]  <= dir_new;
                        ch_q            <= ch_q + 1'b1;
                        // The last channel bypasses the shadow so every duty lands on the same edge.
                        if (last_ch) begin
                            update_done_q <= 1'b1;
                            for (int i = 0; i < CH; i++) begin
                                duty_q[i] <= (i == CH - 1) ? duty_new : duty_sh_q[i];
                                dir_q[i]  <= (i == CH - 1) ? dir_new : dir_sh_q[i];
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef PID_DTERM_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            kd_q <= '0;
            for (int i = 0; i < CH; i++) begin
                err_prev_q[i] <= '0;
            end
        end else if (!enable) begin
            for (int i = 0; i < CH; i++) begin
                err_prev_q[i] <= '0;
            end
        end else if (state_q == LATCH) begin
            kd_q <= kd;
        end else if (state_q == CALC) begin
            err_prev_q[ch_q] <= ERR_W'(err_a);
        end
    end
`endif

    always_comb begin
        pwm_out = '0;
        for (int i = 0; i < CH; i++) begin
            pwm_out[i] = (pwm_cnt_q < duty_q[i]);
        end
    end

    assign dir         = dir_q;
    assign update_done = update_done_q;

endmodule
